// File: rtl/mc_control_fsm_pkg.sv
// Shared constants and types for the TSC multi-cycle control sequencer.
package mc_control_fsm_pkg;

    localparam int unsigned OPC_W   = 4;
    localparam int unsigned FUNC_W  = 6;
    localparam int unsigned SEL_W   = 2;
    localparam int unsigned STATE_W = 3;

    // Opcode field values (IR[15:12])
    localparam logic [OPC_W-1:0] OP_BNE   = 4'd0;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'd1;
    localparam logic [OPC_W-1:0] OP_BGZ   = 4'd2;
    localparam logic [OPC_W-1:0] OP_BLZ   = 4'd3;
    localparam logic [OPC_W-1:0] OP_ADI   = 4'd4;
    localparam logic [OPC_W-1:0] OP_ORI   = 4'd5;
    localparam logic [OPC_W-1:0] OP_LHI   = 4'd6;
    localparam logic [OPC_W-1:0] OP_LWD   = 4'd7;
    localparam logic [OPC_W-1:0] OP_SWD   = 4'd8;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'd9;
    localparam logic [OPC_W-1:0] OP_JAL   = 4'd10;
    localparam logic [OPC_W-1:0] OP_RTYPE = 4'd15;

    // Func field values for opcode 15 (IR[5:0]); ALU ops occupy 0..7
    localparam logic [FUNC_W-1:0] FN_SHR = 6'd7;
    localparam logic [FUNC_W-1:0] FN_JPR = 6'd25;
    localparam logic [FUNC_W-1:0] FN_JRL = 6'd26;
    localparam logic [FUNC_W-1:0] FN_WWD = 6'd28;
    localparam logic [FUNC_W-1:0] FN_HLT = 6'd29;

    // PC source select
    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [SEL_W-1:0] PC_SRC_JTGT   = 2'd2;
    localparam logic [SEL_W-1:0] PC_SRC_RS     = 2'd3;

    // ALU operand selects
    localparam logic             ALUA_PC  = 1'b0;
    localparam logic             ALUA_RS  = 1'b1;
    localparam logic [SEL_W-1:0] ALUB_ONE = 2'd0;
    localparam logic [SEL_W-1:0] ALUB_RT  = 2'd1;
    localparam logic [SEL_W-1:0] ALUB_IMM = 2'd2;

    // Register-file write address and data selects
    localparam logic [SEL_W-1:0] DST_RT    = 2'd0;
    localparam logic [SEL_W-1:0] DST_RD    = 2'd1;
    localparam logic [SEL_W-1:0] DST_R2    = 2'd2;
    localparam logic [SEL_W-1:0] WD_ALUOUT = 2'd0;
    localparam logic [SEL_W-1:0] WD_MDR    = 2'd1;
    localparam logic [SEL_W-1:0] WD_PC     = 2'd2;

    // Sequencer states; fixed encoding so monitors can decode them
    typedef enum logic [STATE_W-1:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // Instruction class flags; all-zero means undefined (retired as NOP)
    typedef struct packed {
        logic is_rtype_alu;
        logic is_itype_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_jump;
        logic is_jreg;
        logic is_link;
        logic is_wwd;
        logic is_hlt;
    } inst_class_t;

endpackage

// File: rtl/mc_control_fsm_inst_class.sv
// Combinational instruction classifier from the IR opcode/func fields.
module mc_inst_class
    import mc_control_fsm_pkg::*;
(
    input  logic [OPC_W-1:0]  opcode,
    input  logic [FUNC_W-1:0] func,
    output inst_class_t       cls
);

    // Decode opcode, then func for the register-format group
    always_comb begin
        cls = '0;
        case (opcode)
            OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: cls.is_branch    = 1'b1;
            OP_ADI, OP_ORI, OP_LHI:         cls.is_itype_alu = 1'b1;
            OP_LWD:                         cls.is_load      = 1'b1;
            OP_SWD:                         cls.is_store     = 1'b1;
            OP_JMP:                         cls.is_jump      = 1'b1;
            OP_JAL: begin
                cls.is_jump = 1'b1;
                cls.is_link = 1'b1;
            end
            OP_RTYPE: begin
                if (func <= FN_SHR) begin
                    cls.is_rtype_alu = 1'b1;
                end else begin
                    case (func)
                        FN_JPR: begin
                            cls.is_jump = 1'b1;
                            cls.is_jreg = 1'b1;
                        end
                        FN_JRL: begin
                            cls.is_jump = 1'b1;
                            cls.is_jreg = 1'b1;
                            cls.is_link = 1'b1;
                        end
                        FN_WWD:  cls.is_wwd = 1'b1;
                        FN_HLT:  cls.is_hlt = 1'b1;
                        default: cls = '0;
                    endcase
                end
            end
            default: cls = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the 16-bit TSC CPU.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
#(
    parameter int unsigned WORD_SIZE = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [OPC_W-1:0]     opcode,
    input  logic [FUNC_W-1:0]    func,
    input  logic                 alu_zero,
    input  logic                 mem_ready,
    output logic                 read_m,
    output logic                 write_m,
    output logic                 i_or_d,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_write_cond,
    output logic [SEL_W-1:0]     pc_src,
    output logic                 alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic [OPC_W-1:0]     alu_opcode,
    output logic [FUNC_W-1:0]    alu_func,
    output logic                 reg_write,
    output logic [SEL_W-1:0]     reg_dst,
    output logic [SEL_W-1:0]     mem_to_reg,
    output logic                 wwd,
    output logic                 halt,
    output logic                 retire,
    output logic [WORD_SIZE-1:0] num_inst
);

    state_t      state;
    state_t      state_nxt;
    inst_class_t cls;
    logic        is_undef;
    logic        needs_ex;
    logic        unused_alu_zero;

    // Branch qualification by alu_zero happens in the datapath via pc_write_cond
    assign unused_alu_zero = alu_zero;

    mc_inst_class u_inst_class (
        .opcode (opcode),
        .func   (func),
        .cls    (cls)
    );

    assign is_undef = (cls == '0);
    assign needs_ex = cls.is_rtype_alu | cls.is_itype_alu | cls.is_load
                    | cls.is_store | cls.is_branch;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IF;
        end else begin
            state <= state_nxt;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_inst <= '0;
        end else if (retire) begin
            num_inst <= num_inst + WORD_SIZE'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IF: begin
                if (mem_ready) state_nxt = ST_ID;
            end
            ST_ID: begin
                if (cls.is_hlt)    state_nxt = ST_HALT;
                else if (needs_ex) state_nxt = ST_EX;
                else               state_nxt = ST_IF;
            end
            ST_EX: begin
                if (cls.is_rtype_alu || cls.is_itype_alu)  state_nxt = ST_WB;
                else if (cls.is_load || cls.is_store)      state_nxt = ST_MEM;
                else                                       state_nxt = ST_IF;
            end
            ST_MEM: begin
                if (mem_ready) state_nxt = cls.is_load ? ST_WB : ST_IF;
            end
            ST_WB:   state_nxt = ST_IF;
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IF;
        endcase
    end

    // Output decode; reset forces every output low without waiting for a clock
    always_comb begin
        read_m        = 1'b0;
        write_m       = 1'b0;
        i_or_d        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = PC_SRC_ALU;
        alu_src_a     = ALUA_PC;
        alu_src_b     = ALUB_ONE;
        alu_opcode    = '0;
        alu_func      = '0;
        reg_write     = 1'b0;
        reg_dst       = DST_RT;
        mem_to_reg    = WD_ALUOUT;
        wwd           = 1'b0;
        halt          = 1'b0;
        retire        = 1'b0;
        if (reset_n) begin
            case (state)
                ST_IF: begin
                    read_m     = 1'b1;
                    alu_opcode = OP_ADI;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_ID: begin
                    alu_src_b  = ALUB_IMM;
                    alu_opcode = OP_ADI;
                    if (cls.is_jump) begin
                        pc_write = 1'b1;
                        pc_src   = cls.is_jreg ? PC_SRC_RS : PC_SRC_JTGT;
                        retire   = 1'b1;
                    end
                    if (cls.is_link) begin
                        reg_write  = 1'b1;
                        reg_dst    = DST_R2;
                        mem_to_reg = WD_PC;
                    end
                    if (cls.is_wwd) begin
                        wwd    = 1'b1;
                        retire = 1'b1;
                    end
                    if (cls.is_hlt || is_undef) retire = 1'b1;
                end
                ST_EX: begin
                    alu_src_a = ALUA_RS;
                    if (cls.is_rtype_alu) begin
                        alu_src_b  = ALUB_RT;
                        alu_opcode = OP_RTYPE;
                        alu_func   = func;
                    end else if (cls.is_itype_alu) begin
                        alu_src_b  = ALUB_IMM;
                        alu_opcode = opcode;
                    end else if (cls.is_load || cls.is_store) begin
                        alu_src_b  = ALUB_IMM;
                        alu_opcode = OP_ADI;
                    end else if (cls.is_branch) begin
                        alu_src_b     = ALUB_RT;
                        alu_opcode    = opcode;
                        pc_write_cond = 1'b1;
                        pc_src        = PC_SRC_ALUOUT;
                        retire        = 1'b1;
                    end
                end
                ST_MEM: begin
                    i_or_d = 1'b1;
                    if (cls.is_load) begin
                        read_m = 1'b1;
                    end else if (cls.is_store) begin
                        write_m = 1'b1;
                        retire  = mem_ready;
                    end
                end
                ST_WB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                    if (cls.is_rtype_alu) reg_dst    = DST_RD;
                    if (cls.is_load)      mem_to_reg = WD_MDR;
                end
                ST_HALT: halt = 1'b1;
                default: halt = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Randomized self-checking bench for mc_control_fsm against a per-instruction trace model.
module tb_mc_control_fsm;

    // ISA encodings
    localparam logic [3:0] BNE = 4'd0, BEQ = 4'd1, BGZ = 4'd2, BLZ = 4'd3;
    localparam logic [3:0] ADI = 4'd4, ORI = 4'd5, LHI = 4'd6, LWD = 4'd7;
    localparam logic [3:0] SWD = 4'd8, JMP = 4'd9, JAL = 4'd10, RTY = 4'd15;
    localparam logic [5:0] F_ADD = 6'd0, F_JPR = 6'd25, F_JRL = 6'd26;
    localparam logic [5:0] F_WWD = 6'd28, F_HLT = 6'd29;

    typedef enum int {K_RALU, K_IALU, K_LWD, K_SWD, K_BR, K_JMP, K_JAL,
                      K_JPR, K_JRL, K_WWD, K_HLT, K_NOP} kind_t;

    typedef struct packed {
        logic       read_m;
        logic       write_m;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [3:0] alu_opcode;
        logic [5:0] alu_func;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       wwd;
        logic       halt;
        logic       retire;
    } ctl_t;

    typedef struct packed {
        logic [3:0] op;
        logic [5:0] fn;
        logic       mr;
        logic       az;
        ctl_t       ctl;
    } step_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] opcode = '0;
    logic [5:0] func = '0;
    logic alu_zero = 1'b0;
    logic mem_ready = 1'b0;

    logic read_m, write_m, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
    logic alu_src_a, reg_write, wwd, halt, retire;
    logic [3:0] alu_opcode;
    logic [5:0] alu_func;
    logic [15:0] num_inst;

    logic unused_read_m, unused_write_m, unused_i_or_d, unused_ir_write;
    logic unused_pc_write, unused_pc_write_cond, unused_alu_src_a;
    logic unused_reg_write, unused_wwd, unused_halt, unused_retire;
    logic [1:0] unused_pc_src, unused_alu_src_b, unused_reg_dst, unused_mem_to_reg;
    logic [3:0] unused_alu_opcode;
    logic [5:0] unused_alu_func;
    logic [3:0] num_inst_s;

    ctl_t obs;
    assign obs = {read_m, write_m, i_or_d, ir_write, pc_write, pc_write_cond,
                  pc_src, alu_src_a, alu_src_b, alu_opcode, alu_func,
                  reg_write, reg_dst, mem_to_reg, wwd, halt, retire};

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    logic [15:0] cnt = '0;
    step_t q[$];

    always #5 clk = ~clk;

    mc_control_fsm #(.WORD_SIZE(16)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .read_m(read_m), .write_m(write_m), .i_or_d(i_or_d), .ir_write(ir_write),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_opcode(alu_opcode),
        .alu_func(alu_func), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .wwd(wwd), .halt(halt), .retire(retire),
        .num_inst(num_inst)
    );

    // Narrow counter copy exercises the wrap from all-ones back to zero
    mc_control_fsm #(.WORD_SIZE(4)) dut_s (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .func(func),
        .alu_zero(alu_zero), .mem_ready(mem_ready),
        .read_m(unused_read_m), .write_m(unused_write_m), .i_or_d(unused_i_or_d),
        .ir_write(unused_ir_write), .pc_write(unused_pc_write),
        .pc_write_cond(unused_pc_write_cond), .pc_src(unused_pc_src),
        .alu_src_a(unused_alu_src_a), .alu_src_b(unused_alu_src_b),
        .alu_opcode(unused_alu_opcode), .alu_func(unused_alu_func),
        .reg_write(unused_reg_write), .reg_dst(unused_reg_dst),
        .mem_to_reg(unused_mem_to_reg), .wwd(unused_wwd), .halt(unused_halt),
        .retire(unused_retire), .num_inst(num_inst_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    endtask

    function automatic kind_t kind_of(input logic [3:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_NOP;
        case (op)
            BNE, BEQ, BGZ, BLZ: k = K_BR;
            ADI, ORI, LHI:      k = K_IALU;
            LWD:                k = K_LWD;
            SWD:                k = K_SWD;
            JMP:                k = K_JMP;
            JAL:                k = K_JAL;
            RTY: begin
                if (fn < 6'd8)        k = K_RALU;
                else if (fn == F_JPR) k = K_JPR;
                else if (fn == F_JRL) k = K_JRL;
                else if (fn == F_WWD) k = K_WWD;
                else if (fn == F_HLT) k = K_HLT;
            end
            default: k = K_NOP;
        endcase
        return k;
    endfunction

    function automatic void push(input logic [3:0] op, input logic [5:0] fn,
                                 input logic mr, input int az, input ctl_t c);
        step_t s;
        s.op  = op;
        s.fn  = fn;
        s.mr  = mr;
        s.az  = (az < 0) ? 1'($urandom_range(1, 0)) : 1'(az);
        s.ctl = c;
        q.push_back(s);
    endfunction

    // Expected cycle-by-cycle trace of one instruction, with wif/wmem memory wait cycles
    task automatic add_inst(input logic [3:0] op, input logic [5:0] fn,
                            input int wif, input int wmem, input int az);
        kind_t k;
        ctl_t  c;
        k = kind_of(op, fn);
        // fetch: read at PC, PC+1 computed; IR/PC load only on the ready cycle
        c = '0;
        c.read_m = 1'b1;
        c.alu_opcode = ADI;
        for (int i = 0; i < wif; i++) push(op, fn, 1'b0, az, c);
        c.ir_write = 1'b1;
        c.pc_write = 1'b1;
        push(op, fn, 1'b1, az, c);
        // decode: branch target PC+imm computed every time
        c = '0;
        c.alu_src_b = 2'd2;
        c.alu_opcode = ADI;
        case (k)
            K_JMP, K_JAL, K_JPR, K_JRL: begin
                c.pc_write = 1'b1;
                c.pc_src = (k == K_JPR || k == K_JRL) ? 2'd3 : 2'd2;
                c.retire = 1'b1;
                if (k == K_JAL || k == K_JRL) begin
                    c.reg_write = 1'b1;
                    c.reg_dst = 2'd2;
                    c.mem_to_reg = 2'd2;
                end
            end
            K_WWD: begin
                c.wwd = 1'b1;
                c.retire = 1'b1;
            end
            K_HLT, K_NOP: c.retire = 1'b1;
            default: c.retire = 1'b0;
        endcase
        push(op, fn, 1'($urandom_range(1, 0)), az, c);
        if (c.retire) return;
        // execute
        c = '0;
        c.alu_src_a = 1'b1;
        case (k)
            K_RALU: begin c.alu_src_b = 2'd1; c.alu_opcode = 4'd15; c.alu_func = fn; end
            K_IALU: begin c.alu_src_b = 2'd2; c.alu_opcode = op; end
            K_LWD, K_SWD: begin c.alu_src_b = 2'd2; c.alu_opcode = ADI; end
            default: begin
                c.alu_src_b = 2'd1;
                c.alu_opcode = op;
                c.pc_write_cond = 1'b1;
                c.pc_src = 2'd1;
                c.retire = 1'b1;
            end
        endcase
        push(op, fn, 1'($urandom_range(1, 0)), az, c);
        if (k == K_BR) return;
        // memory access at ALUOut, request held until ready
        if (k == K_LWD || k == K_SWD) begin
            c = '0;
            c.i_or_d = 1'b1;
            c.read_m = (k == K_LWD);
            c.write_m = (k == K_SWD);
            for (int i = 0; i < wmem; i++) push(op, fn, 1'b0, az, c);
            c.retire = (k == K_SWD);
            push(op, fn, 1'b1, az, c);
            if (k == K_SWD) return;
        end
        // write back
        c = '0;
        c.reg_write = 1'b1;
        c.retire = 1'b1;
        c.reg_dst = (k == K_RALU) ? 2'd1 : 2'd0;
        c.mem_to_reg = (k == K_LWD) ? 2'd1 : 2'd0;
        push(op, fn, 1'($urandom_range(1, 0)), az, c);
    endtask

    // Apply queued steps one cycle each; called and returns at posedge+1
    task automatic run_steps(input int n);
        step_t s;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            s = q.pop_front();
            opcode = s.op;
            func = s.fn;
            mem_ready = s.mr;
            alu_zero = s.az;
            @(negedge clk);
            check($sformatf("ctl cyc%0d op%0d fn%0d", cyc, s.op, s.fn), 32'(obs), 32'(s.ctl));
            check($sformatf("num_inst cyc%0d", cyc), 32'(num_inst), 32'(cnt));
            check($sformatf("num_inst4 cyc%0d", cyc), 32'(num_inst_s), 32'(cnt[3:0]));
            if (s.ctl.retire) cnt = cnt + 16'd1;
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Pull reset mid-cycle and confirm everything clears before any edge
    task automatic reset_mid(input string tag);
        #2 reset_n = 1'b0;
        #1;
        check({tag, " outputs"}, 32'(obs), 32'd0);
        check({tag, " num_inst"}, 32'(num_inst), 32'd0);
        check({tag, " num_inst4"}, 32'(num_inst_s), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        cnt = '0;
        q.delete();
    endtask

    // Stall a load/store in MEM, then reset while the request is up
    task automatic reset_in_mem(input logic [3:0] op);
        add_inst(op, 6'd0, 0, 5, -1);
        run_steps(4);
        check("mem request held", 32'((op == SWD) ? write_m : read_m), 32'd1);
        check("mem addr is aluout", 32'(i_or_d), 32'd1);
        reset_mid((op == SWD) ? "reset in SWD MEM" : "reset in LWD MEM");
    endtask

    initial begin
        logic [3:0] op;
        logic [5:0] fn;
        int sel;
        @(negedge clk);
        check("reset outputs", 32'(obs), 32'd0);
        check("reset num_inst", 32'(num_inst), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        add_inst(RTY, F_ADD, 0, 0, -1);
        add_inst(LWD, 6'd3, 3, 2, -1);
        add_inst(BEQ, 6'd0, 0, 0, 1);
        add_inst(BEQ, 6'd0, 0, 0, 0);
        add_inst(JAL, 6'd5, 0, 0, -1);
        add_inst(RTY, F_JRL, 0, 0, -1);
        add_inst(RTY, F_WWD, 0, 0, -1);
        add_inst(SWD, 6'd1, 1, 0, -1);
        add_inst(4'd12, 6'd0, 0, 0, -1);
        run_steps(q.size());

        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(15, 0));
            fn = 6'($urandom_range(63, 0));
            if (op == RTY) begin
                sel = int'($urandom_range(3, 0));
                if (sel < 2) fn = 6'($urandom_range(7, 0));
                else if (sel == 2) begin
                    case ($urandom_range(2, 0))
                        0: fn = F_JPR;
                        1: fn = F_JRL;
                        default: fn = F_WWD;
                    endcase
                end
                if (fn == F_HLT) fn = F_ADD;
            end
            add_inst(op, fn, int'($urandom_range(2, 0)), int'($urandom_range(3, 0)), -1);
            run_steps(q.size());
        end

        add_inst(RTY, F_HLT, 1, 0, -1);
        for (int i = 0; i < 8; i++) begin
            ctl_t h;
            h = '0;
            h.halt = 1'b1;
            push(RTY, F_HLT, 1'($urandom_range(1, 0)), -1, h);
        end
        run_steps(q.size());
        reset_mid("reset in HALT");

        add_inst(RTY, F_ADD, 0, 0, -1);
        run_steps(q.size());
        reset_in_mem(SWD);
        reset_in_mem(LWD);
        add_inst(ORI, 6'd9, 0, 0, -1);
        run_steps(q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
